// File: rtl/regfile_sb_if.sv
// Bundle for regfile_sb: operand reads, issue request, writeback and scoreboard status.
// master = decode/issue/writeback side, slave = register file.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            iss_valid, iss_use1, iss_use2, iss_wen;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic [AW:0]     busy_cnt;
  logic            wb_err;

  modport master (
    output rs1, rs2, iss_valid, iss_use1, iss_use2, iss_wen, iss_rd,
           wb_valid, wb_rd, wb_data, flush,
    input  rdata1, rdata2, iss_ready, busy_cnt, wb_err
  );
  modport slave (
    input  rs1, rs2, iss_valid, iss_use1, iss_use2, iss_wen, iss_rd,
           wb_valid, wb_rd, wb_data, flush,
    output rdata1, rdata2, iss_ready, busy_cnt, wb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R1W integer register file with per-register busy scoreboard for RAW/WAW issue gating.
// Define REGFILE_SB_BYPASS_EN for same-cycle writeback forwarding to reads and hazard checks.
module regfile_sb_entry #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic            set,
  input  logic            clr,
  input  logic            flush,
  output logic [XLEN-1:0] q,
  output logic            busy
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RESET_VAL;
    else if (we) q <= wdata;
  end

  // flush beats set, set beats writeback clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        busy <= 1'b0;
    else if (flush) busy <= 1'b0;
    else if (set)   busy <= 1'b1;
    else if (clr)   busy <= 1'b0;
  end
endmodule

module regfile_sb #(
  parameter int              XLEN      = 32,
  parameter int              NREGS     = 32,
  parameter int              AW        = $clog2(NREGS),
  parameter int              ZERO_REG  = 1,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic                       fwd1, fwd2, wb_hit_rd;
  logic                       raw1, raw2, waw;
  logic                       iss_set, wb_we, cnt_inc, cnt_dec;
  logic [AW:0]                cnt_q;
  logic                       err_q;

  function automatic logic is_zero(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

`ifdef REGFILE_SB_BYPASS_EN
  assign fwd1      = bus.wb_valid && (bus.wb_rd == bus.rs1);
  assign fwd2      = bus.wb_valid && (bus.wb_rd == bus.rs2);
  assign wb_hit_rd = bus.wb_valid && (bus.wb_rd == bus.iss_rd);
`else
  assign fwd1      = 1'b0;
  assign fwd2      = 1'b0;
  assign wb_hit_rd = 1'b0;
`endif

  assign bus.rdata1 = is_zero(bus.rs1) ? '0 : fwd1 ? bus.wb_data : regs[bus.rs1];
  assign bus.rdata2 = is_zero(bus.rs2) ? '0 : fwd2 ? bus.wb_data : regs[bus.rs2];

  // busy[0] never sets under ZERO_REG, so no explicit zero masking is needed here
  assign raw1          = bus.iss_use1 && busy[bus.rs1] && !fwd1;
  assign raw2          = bus.iss_use2 && busy[bus.rs2] && !fwd2;
  assign waw           = bus.iss_wen && busy[bus.iss_rd] && !wb_hit_rd;
  assign bus.iss_ready = !raw1 && !raw2 && !waw && !bus.flush;

  assign iss_set = bus.iss_valid && bus.iss_ready && bus.iss_wen && !is_zero(bus.iss_rd);
  assign wb_we   = bus.wb_valid && !is_zero(bus.wb_rd);

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : gen_entry
      regfile_sb_entry #(.XLEN(XLEN), .RESET_VAL(RESET_VAL)) u_entry (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_we && (bus.wb_rd == AW'(i))),
        .wdata (bus.wb_data),
        .set   (iss_set && (bus.iss_rd == AW'(i))),
        .clr   (wb_we && (bus.wb_rd == AW'(i))),
        .flush (bus.flush),
        .q     (regs[i]),
        .busy  (busy[i])
      );
    end
  endgenerate

  // Count only real transitions: an already-busy set or a set-wins clear is net zero
  assign cnt_inc = iss_set && !busy[bus.iss_rd];
  assign cnt_dec = wb_we && busy[bus.wb_rd] && !(iss_set && (bus.iss_rd == bus.wb_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt_q <= '0;
    else if (bus.flush) cnt_q <= '0;
    else                cnt_q <= cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         err_q <= 1'b0;
    else if (wb_we && !busy[bus.wb_rd]) err_q <= 1'b1;
  end

  assign bus.busy_cnt = cnt_q;
  assign bus.wb_err   = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; bypass expectations follow REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb_if #(.XLEN(32), .NREGS(32)) bus ();
  regfile_sb #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.rs1 = '0; bus.rs2 = '0;
    bus.iss_valid = 0; bus.iss_use1 = 0; bus.iss_use2 = 0; bus.iss_wen = 0; bus.iss_rd = '0;
    bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.flush = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    rst = 0; #1;
    for (int r = 1; r < 32; r++) begin
      bus.rs1 = 5'(r); bus.rs2 = 5'(r); #1;
      checks++;
      if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
        errors++; $display("FAIL reset_rdata x%0d got %h/%h exp 0", r, bus.rdata1, bus.rdata2);
      end
    end
    checks++;
    if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d exp 0", bus.busy_cnt); end
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %b exp 1", bus.iss_ready); end
    checks++;
    if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", bus.wb_err); end
  endtask

  task automatic test_raw();
    idle();
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 5'd5; #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL raw_issue5 got %b exp 1", bus.iss_ready); end
    step();
    bus.iss_wen = 0; bus.iss_use1 = 1; bus.rs1 = 5'd5; #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", bus.iss_ready); end
    checks++;
    if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL raw_busy_cnt got %0d exp 1", bus.busy_cnt); end
    bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF; #1;
    checks++;
    if (bus.iss_ready !== BYP) begin errors++; $display("FAIL raw_wb_cycle_ready got %b exp %b", bus.iss_ready, BYP); end
    checks++;
    if (bus.rdata1 !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      errors++; $display("FAIL raw_wb_cycle_rdata1 got %h exp %h", bus.rdata1, BYP ? 32'hDEADBEEF : 32'h0);
    end
    step();
    bus.wb_valid = 0; #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready got %b exp 1", bus.iss_ready); end
    checks++;
    if (bus.rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_after_wb_rdata1 got %h exp deadbeef", bus.rdata1); end
    checks++;
    if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL raw_after_wb_cnt got %0d exp 0", bus.busy_cnt); end
    idle();
  endtask

  task automatic test_rs2();
    idle();
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 5'd20;
    step();
    bus.iss_valid = 0; bus.iss_wen = 0; bus.rs2 = 5'd20; bus.iss_use2 = 0; #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL rs2_unused_ready got %b exp 1", bus.iss_ready); end
    bus.iss_use2 = 1; #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL rs2_stall got %b exp 0", bus.iss_ready); end
    bus.wb_valid = 1; bus.wb_rd = 5'd20; bus.wb_data = 32'h0BADF00D;
    step();
    bus.wb_valid = 0; #1;
    checks++;
    if (bus.rdata2 !== 32'h0BADF00D) begin errors++; $display("FAIL rs2_rdata2 got %h exp 0badf00d", bus.rdata2); end
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL rs2_release got %b exp 1", bus.iss_ready); end
    idle();
  endtask

  task automatic test_waw();
    idle();
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 5'd7;
    step(); #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL waw_block got %b exp 0", bus.iss_ready); end
    step();
    checks++;
    if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL waw_blocked_cnt got %0d exp 1", bus.busy_cnt); end
    bus.wb_valid = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h00000077; #1;
    checks++;
    if (bus.iss_ready !== BYP) begin errors++; $display("FAIL waw_with_wb_ready got %b exp %b", bus.iss_ready, BYP); end
    step();
    bus.wb_valid = 0; bus.iss_valid = 0; #1;
    checks++;
    if (bus.busy_cnt !== (BYP ? 6'd1 : 6'd0)) begin
      errors++; $display("FAIL waw_set_wins_cnt got %0d exp %0d", bus.busy_cnt, BYP ? 1 : 0);
    end
    checks++;
    if (bus.iss_ready !== !BYP) begin errors++; $display("FAIL waw_set_wins_busy7 got %b exp %b", bus.iss_ready, !BYP); end
    if (BYP) begin
      bus.wb_valid = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h00000078;
      step();
      bus.wb_valid = 0;
    end
    #1;
    checks++;
    if (bus.busy_cnt !== 6'd0 || bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL waw_cleanup got cnt %0d err %b exp 0/0", bus.busy_cnt, bus.wb_err);
    end
    idle();
  endtask

  task automatic test_zero();
    idle();
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 5'd0;
    bus.wb_valid = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'h00001234; #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", bus.iss_ready); end
    step();
    idle(); bus.rs1 = 5'd0; bus.iss_use1 = 1; #1;
    checks++;
    if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_busy_cnt got %0d exp 0", bus.busy_cnt); end
    checks++;
    if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL zero_rdata1 got %h exp 0", bus.rdata1); end
    checks++;
    if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL zero_wb_err got %b exp 0", bus.wb_err); end
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL zero_not_busy got %b exp 1", bus.iss_ready); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    bus.iss_valid = 1; bus.iss_wen = 1;
    bus.iss_rd = 5'd3; step();
    bus.iss_rd = 5'd4; step();
    bus.iss_rd = 5'd9; step();
    checks++;
    if (bus.busy_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 3", bus.busy_cnt); end
    bus.iss_rd = 5'd10; bus.flush = 1;
    bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h00000033; #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", bus.iss_ready); end
    step();
    idle(); #1;
    checks++;
    if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", bus.busy_cnt); end
    bus.rs1 = 5'd3; #1;
    checks++;
    if (bus.rdata1 !== 32'h00000033) begin errors++; $display("FAIL flush_wb_data got %h exp 00000033", bus.rdata1); end
    bus.iss_wen = 1; bus.iss_rd = 5'd10; #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL flush_rd10_not_set got %b exp 1", bus.iss_ready); end
    bus.iss_rd = 5'd4; #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL flush_rd4_cleared got %b exp 1", bus.iss_ready); end
    checks++;
    if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL flush_wb_err got %b exp 0", bus.wb_err); end
    idle();
  endtask

  task automatic test_err_reset();
    idle();
    bus.wb_valid = 1; bus.wb_rd = 5'd12; bus.wb_data = 32'hCAFE0012;
    step();
    bus.wb_valid = 0; bus.rs1 = 5'd12; #1;
    checks++;
    if (bus.wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", bus.wb_err); end
    checks++;
    if (bus.rdata1 !== 32'hCAFE0012) begin errors++; $display("FAIL err_write_done got %h exp cafe0012", bus.rdata1); end
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 5'd15;
    step();
    bus.iss_valid = 0; #1;
    checks++;
    if (bus.busy_cnt !== 6'd1 || bus.wb_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got cnt %0d err %b exp 1/1", bus.busy_cnt, bus.wb_err);
    end
    @(posedge clk); #3;
    rst = 1; #1;
    bus.rs2 = 5'd5; #1;
    checks++;
    if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL async_rst_wb_err got %b exp 0", bus.wb_err); end
    checks++;
    if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL async_rst_x12 got %h exp 0", bus.rdata1); end
    checks++;
    if (bus.rdata2 !== 32'h0) begin errors++; $display("FAIL async_rst_x5 got %h exp 0", bus.rdata2); end
    checks++;
    if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL async_rst_cnt got %0d exp 0", bus.busy_cnt); end
    checks++;
    if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL async_rst_busy15 got %b exp 1", bus.iss_ready); end
    step();
    rst = 0;
    idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_raw();
    test_rs2();
    test_waw();
    test_zero();
    test_flush();
    test_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the rv32 core with a built-in scoreboard. Generalises the plain 2R1W file in width and depth, and adds per-register busy tracking for in-flight producers.
- Sits between decode/issue and writeback.
- Decode reads operands and requests issue. The block grants issue only when RAW/WAW hazards are clear, and marks the destination busy until writeback retires it.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREGS), register index width.
- ZERO_REG, 1, when 1 register 0 reads as 0 and is never written or marked busy.
- RESET_VAL, 0, reset value of every register (XLEN bits).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- rs1  in  AW  read port 1 index
- rs2  in  AW  read port 2 index
- rdata1  out  XLEN  read port 1 data
- rdata2  out  XLEN  read port 2 data
- iss_valid  in  1  decode requests issue of one instruction
- iss_use1  in  1  instruction reads rs1
- iss_use2  in  1  instruction reads rs2
- iss_wen  in  1  instruction writes rd
- iss_rd  in  AW  destination index
- iss_ready  out  1  issue accepted this cycle when iss_valid also high
- wb_valid  in  1  writeback strobe
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  synchronous clear of all busy bits (pipeline kill)
- busy_cnt  out  AW+1  number of registers currently busy
- wb_err  out  1  sticky: writeback hit a non-busy register

Behaviour:
- Reset (async, rst=1): all registers = RESET_VAL; busy[] = 0; busy_cnt = 0; wb_err = 0. Asserting rst mid-operation discards all pending state immediately.
- Read:
  - rdataN = reg[rsN], combinational.
  - With ZERO_REG=1, index 0 returns 0.
  - A write becomes visible on reads the cycle after wb_valid (unless the feature macro below is defined).
- Write: on a rising edge with wb_valid=1, reg[wb_rd] <= wb_data and busy[wb_rd] is cleared. Skipped when wb_rd==0 and ZERO_REG=1.
- Hazard terms:
  - raw1 = iss_use1 & busy[rs1] & !(fwd1)
  - raw2 = iss_use2 & busy[rs2] & !(fwd2)
  - waw = iss_wen & busy[iss_rd]
  - fwd terms are 0 unless the feature is enabled.
  - Index 0 is never busy when ZERO_REG=1.
- iss_ready = !raw1 & !raw2 & !waw & !flush. It is combinational and does not depend on iss_valid.
- Issue: when iss_valid & iss_ready & iss_wen and iss_rd is not the zero register, busy[iss_rd] <= 1 at the next edge.
- Simultaneous issue set and wb clear on the same index: set wins, so busy stays 1. This case is only reachable via forwarding, since waw otherwise blocks issue.
- flush=1: all busy bits clear at the next edge; it overrides issue set in that cycle. wb writes in that cycle still update data.
- busy_cnt: registered; equals popcount(busy) at all times after each edge. Updated incrementally by +1 / -1 / 0 per edge; a flush loads 0.
- wb_err: set when wb_valid and wb_rd is not busy and wb_rd is not the zero register. Cleared only by rst. The write still occurs.
- One writeback per cycle; at most one issue per cycle.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - Write-through forwarding: if wb_valid and wb_rd==rsN (non-zero), rdataN = wb_data in the same cycle.
  - fwdN = wb_valid & (wb_rd==rsN), so RAW on a register retiring this cycle does not stall.
  - waw is also suppressed when wb_rd==iss_rd. Set-wins applies.
- Undefined: no forwarding. fwd terms are 0, and reads see the old value until the next cycle.

Test Plan:
- Reset: rst pulse, then read x1..x31 -> all rdata = 0, busy_cnt = 0, iss_ready = 1, wb_err = 0.
- RAW stall:
  - Issue rd=5 (accepted).
  - Next cycle, iss_use1=1, rs1=5 -> iss_ready = 0, busy_cnt = 1.
  - wb_rd=5, wb_data=32'hDEADBEEF -> next cycle iss_ready = 1 and rdata1 = DEADBEEF.
  - With bypass: iss_ready = 1 and rdata1 = DEADBEEF in the wb cycle itself.
- WAW and set-wins:
  - Issue rd=7, then a second issue rd=7 -> second is blocked.
  - With bypass, second issue rd=7 coincident with wb_rd=7 -> accepted, busy[7] stays 1, busy_cnt = 1.
- Zero register: issue rd=0 and wb_rd=0 with data 32'h1234 -> busy_cnt = 0, rdata(rs=0) = 0, wb_err = 0.
- Flush: issue rd=3, 4, 9 (busy_cnt = 3), then flush=1 with a concurrent issue rd=10 -> iss_ready = 0, next cycle busy_cnt = 0.
- Spurious wb and async reset: wb_rd=12 while not busy -> wb_err = 1 and x12 updated. rst asserted mid-cycle -> wb_err = 0 and x12 = 0 immediately.
